bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter S0_BASE, 8'h00, base address of slave 0 window (memory).
REQ-002 Parameter S1_BASE, 8'h20, base address of slave 1 window (timer registers).
REQ-003 Parameter WIN_MASK, 8'hE0, address bits compared against each base; the window size is 32 bytes.
REQ-004 Parameter TIMEOUT_CYCLES, 16, grant-hold limit used only when BUS_TIMEOUT_EN is defined.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- M0_req, M1_req  in  1 each  bus request from master 0 and master 1.
- M0_wr, M1_wr  in  1 each  write strobe from each master.
- M0_address, M1_address  in  8 each  address from each master.
- M0_dout, M1_dout  in  8 each  write data from each master.
- M0_grant, M1_grant  out  1 each  registered grant to each master.
- M_din  out  8  read data returned to the granted master.
- S0_sel, S1_sel  out  1 each  slave selects.
- S_address  out  8  address routed to the slaves.
- S_wr  out  1  write strobe routed to the slaves.
- S_din  out  8  write data routed to the slaves.
- S0_dout, S1_dout  in  8 each  read data from each slave.
- bus_timeout  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-007 Arbiter FSM SHALL have two states: GRANT_M0 and GRANT_M1; exactly one grant output is high at any time.
REQ-008 In GRANT_M0: if M0_req=0 and M1_req=1, the FSM goes to GRANT_M1 on the next edge; otherwise it stays.
REQ-009 In GRANT_M1: if M1_req=0, the FSM goes to GRANT_M0 on the next edge; otherwise it stays. When idle, the bus parks on M0.
REQ-010 Grant outputs SHALL be registered and decoded directly from the state, with one cycle of latency from a request to its grant.
REQ-011 Simultaneous requests from GRANT_M0 with M0_req=1: M0 keeps the bus. The current owner is never preempted, except as REQ-019 allows.
REQ-012 S_address, S_wr and S_din SHALL combinationally mux the granted master's address, wr and dout.
REQ-013 Slave selects:
- S0_sel = granted_req AND ((S_address AND WIN_MASK) == S0_BASE).
- S1_sel is the same comparison against S1_BASE.
- At most one select is high.
REQ-014 S_wr SHALL be forced to 0 whenever the granted master's req is 0.
REQ-015 M_din SHALL be S0_dout when S0_sel=1, S1_dout when S1_sel=1, and 8'h00 otherwise (unmapped address or no request).
REQ-016 M_din SHALL be driven regardless of which master is granted; masters sample it only while their own grant=1.

Reset
REQ-017 While reset_n=0, the state SHALL be GRANT_M0, so M0_grant=1, M1_grant=0 and bus_timeout=0. The timeout counter SHALL be 0.
REQ-018 Reset asserted mid-transfer SHALL return the grant to M0 immediately (asynchronously); combinational outputs then follow M0's inputs.

Configuration
REQ-019 With BUS_TIMEOUT_EN defined:
- A 5-bit hold counter increments each cycle the owner keeps req=1 while the other master requests.
- Otherwise the counter clears.
- When the count reaches TIMEOUT_CYCLES-1, the grant switches to the other master on the next edge, the counter clears, and bus_timeout pulses high for one cycle.
REQ-020 Without BUS_TIMEOUT_EN, no counter is built, bus_timeout is tied to 0, and only REQ-008/009 transitions apply.

Structure
REQ-021 Package bus_pkg SHALL hold the arbiter state typedef (GRANT_M0, GRANT_M1) and the default address map constants (S0_BASE, S1_BASE, WIN_MASK).
REQ-022 One sub-module, bus_addr_decoder, SHALL perform the comparisons of REQ-013 and the read mux of REQ-015; the FSM and timeout logic stay in bus_arbiter.

Verification
REQ-023 Reset -> M0_grant=1, M1_grant=0, bus_timeout=0; with all req=0, M_din=8'h00 and S0_sel=S1_sel=0.
REQ-024 M1_req=1, M1_address=8'h25, M1_wr=1, M1_dout=8'hA5 -> M1_grant=1 after one edge; S1_sel=1, S_din=8'hA5, S_wr=1.
REQ-025 M0 owns the bus, M0_address=8'h03, S0_dout=8'h5C, M1_req=1 -> M_din=8'h5C, M0 keeps the grant until M0_req drops, and M1_grant rises the following edge.
REQ-026 M0_address=8'h80 with M0_req=1 -> S0_sel=S1_sel=0 and M_din=8'h00.
REQ-027 BUS_TIMEOUT_EN defined, M1 holds req for 20 cycles while M0_req=1 -> the grant returns to M0 after 16 cycles with a one-cycle bus_timeout pulse. Without the macro, M1 holds the grant for all 20 cycles.
REQ-028 reset_n pulsed low while M1_grant=1 -> M0_grant=1 asynchronously, with no bus_timeout pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared arbiter state encoding and default address map for the two-master bus.
package bus_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t GRANT_M0 = 1'b0;
  localparam arb_state_t GRANT_M1 = 1'b1;

  localparam logic [7:0] S0_BASE_DEFAULT  = 8'h00;
  localparam logic [7:0] S1_BASE_DEFAULT  = 8'h20;
  localparam logic [7:0] WIN_MASK_DEFAULT = 8'hE0;

endpackage

// File: rtl/bus_addr_decoder.sv
// Slave window decode and read-data return mux for the granted master's address.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter logic [7:0] S0_BASE  = S0_BASE_DEFAULT,
  parameter logic [7:0] S1_BASE  = S1_BASE_DEFAULT,
  parameter logic [7:0] WIN_MASK = WIN_MASK_DEFAULT
) (
  input  logic       granted_req,
  input  logic [7:0] address,
  input  logic [7:0] s0_dout,
  input  logic [7:0] s1_dout,
  output logic       s0_sel,
  output logic       s1_sel,
  output logic [7:0] m_din
);

  logic s0_hit;
  logic s1_hit;

  assign s0_hit = (address & WIN_MASK) == S0_BASE;
  assign s1_hit = (address & WIN_MASK) == S1_BASE;

  // Slave 0 wins if the windows were ever configured to overlap, keeping selects one-hot.
  assign s0_sel = granted_req && s0_hit;
  assign s1_sel = granted_req && s1_hit && !s0_hit;

  always_comb begin
    m_din = 8'h00;
    if (s0_sel) begin
      m_din = s0_dout;
    end else if (s1_sel) begin
      m_din = s1_dout;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, two-slave bus arbiter that parks on M0 and never preempts the owner.
// Define BUS_TIMEOUT_EN to add a grant-hold timeout that forces a handover.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter logic [7:0] S0_BASE        = S0_BASE_DEFAULT,
  parameter logic [7:0] S1_BASE        = S1_BASE_DEFAULT,
  parameter logic [7:0] WIN_MASK       = WIN_MASK_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       M0_req,
  input  logic       M1_req,
  input  logic       M0_wr,
  input  logic       M1_wr,
  input  logic [7:0] M0_address,
  input  logic [7:0] M1_address,
  input  logic [7:0] M0_dout,
  input  logic [7:0] M1_dout,
  output logic       M0_grant,
  output logic       M1_grant,
  output logic [7:0] M_din,
  output logic       S0_sel,
  output logic       S1_sel,
  output logic [7:0] S_address,
  output logic       S_wr,
  output logic [7:0] S_din,
  input  logic [7:0] S0_dout,
  input  logic [7:0] S1_dout,
  output logic       bus_timeout
);

  arb_state_t state_reg;
  arb_state_t state_next;
  logic       granted_req;
  logic       other_req;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must fit the 5-bit hold counter");
  end

  assign M0_grant = (state_reg == GRANT_M0);
  assign M1_grant = (state_reg == GRANT_M1);

  always_comb begin
    granted_req = M0_req;
    other_req   = M1_req;
    S_address   = M0_address;
    S_din       = M0_dout;
    S_wr        = M0_wr && M0_req;
    if (state_reg == GRANT_M1) begin
      granted_req = M1_req;
      other_req   = M0_req;
      S_address   = M1_address;
      S_din       = M1_dout;
      S_wr        = M1_wr && M1_req;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      GRANT_M0: if (!M0_req && M1_req) state_next = GRANT_M1;
      GRANT_M1: if (!M1_req) state_next = GRANT_M0;
      default:  state_next = GRANT_M0;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [4:0] HOLD_LIMIT = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] hold_cnt_reg;
  logic       timeout_reg;
  logic       hold_active;
  logic       hold_expired;

  assign hold_active  = granted_req && other_req;
  assign hold_expired = hold_active && (hold_cnt_reg == HOLD_LIMIT);
  assign bus_timeout  = timeout_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= GRANT_M0;
      hold_cnt_reg <= 5'd0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= hold_expired;
      if (hold_expired) begin
        // Forced handover: both masters are requesting, so the other one is waiting.
        state_reg    <= (state_reg == GRANT_M0) ? GRANT_M1 : GRANT_M0;
        hold_cnt_reg <= 5'd0;
      end else begin
        state_reg    <= state_next;
        hold_cnt_reg <= hold_active ? hold_cnt_reg + 5'd1 : 5'd0;
      end
    end
  end
`else
  assign bus_timeout = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= GRANT_M0;
    end else begin
      state_reg <= state_next;
    end
  end
`endif

  bus_addr_decoder #(
    .S0_BASE  (S0_BASE),
    .S1_BASE  (S1_BASE),
    .WIN_MASK (WIN_MASK)
  ) u_decoder (
    .granted_req (granted_req),
    .address     (S_address),
    .s0_dout     (S0_dout),
    .s1_dout     (S1_dout),
    .s0_sel      (S0_sel),
    .s1_sel      (S1_sel),
    .m_din       (M_din)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter; adapts its timeout expectations to BUS_TIMEOUT_EN.
module tb_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic       M0_req, M1_req, M0_wr, M1_wr;
  logic [7:0] M0_address, M1_address, M0_dout, M1_dout;
  logic       M0_grant, M1_grant;
  logic [7:0] M_din;
  logic       S0_sel, S1_sel;
  logic [7:0] S_address;
  logic       S_wr;
  logic [7:0] S_din;
  logic [7:0] S0_dout, S1_dout;
  logic       bus_timeout;

  typedef struct {
    string      tag;
    string      sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   pass_count  = 0;
  int   check_count = 0;
  int   fail_count  = 0;

  logic [7:0] addr_tab [6];
  logic       s0_tab   [6];
  logic       s1_tab   [6];
  logic [7:0] din_tab  [6];

`ifdef BUS_TIMEOUT_EN
  localparam bit TIMEOUT_MODE = 1'b1;
`else
  localparam bit TIMEOUT_MODE = 1'b0;
`endif

  bus_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .M0_req      (M0_req),
    .M1_req      (M1_req),
    .M0_wr       (M0_wr),
    .M1_wr       (M1_wr),
    .M0_address  (M0_address),
    .M1_address  (M1_address),
    .M0_dout     (M0_dout),
    .M1_dout     (M1_dout),
    .M0_grant    (M0_grant),
    .M1_grant    (M1_grant),
    .M_din       (M_din),
    .S0_sel      (S0_sel),
    .S1_sel      (S1_sel),
    .S_address   (S_address),
    .S_wr        (S_wr),
    .S_din       (S_din),
    .S0_dout     (S0_dout),
    .S1_dout     (S1_dout),
    .bus_timeout (bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] observe(string sig);
    case (sig)
      "m0_grant":    return {7'd0, M0_grant};
      "m1_grant":    return {7'd0, M1_grant};
      "s0_sel":      return {7'd0, S0_sel};
      "s1_sel":      return {7'd0, S1_sel};
      "s_wr":        return {7'd0, S_wr};
      "bus_timeout": return {7'd0, bus_timeout};
      "m_din":       return M_din;
      "s_address":   return S_address;
      "s_din":       return S_din;
      default:       return 8'hxx;
    endcase
  endfunction

  task automatic expect_sig(string tag, string sig, logic [7:0] exp);
    sb.push_back('{tag, sig, exp});
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] obs;
      e   = sb.pop_front();
      obs = observe(e.sig);
      check_count++;
      assert (obs === e.exp) pass_count++;
      else begin
        fail_count++;
        $error("FAIL %s.%s observed=%h expected=%h", e.tag, e.sig, obs, e.exp);
      end
      $display("check %s.%s observed=%h expected=%h", e.tag, e.sig, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    addr_tab = '{8'h80, 8'h1F, 8'h20, 8'h3F, 8'h40, 8'h00};
    s0_tab   = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    s1_tab   = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    din_tab  = '{8'h00, 8'h5C, 8'h3A, 8'h3A, 8'h00, 8'h5C};

    reset_n = 1'b0;
    M0_req = 1'b0; M1_req = 1'b0; M0_wr = 1'b0; M1_wr = 1'b0;
    M0_address = 8'h00; M1_address = 8'h00; M0_dout = 8'h00; M1_dout = 8'h00;
    S0_dout = 8'h00; S1_dout = 8'h00;

    // Reset state
    #12;
    expect_sig("reset", "m0_grant", 8'h01);
    expect_sig("reset", "m1_grant", 8'h00);
    expect_sig("reset", "bus_timeout", 8'h00);
    expect_sig("reset", "m_din", 8'h00);
    expect_sig("reset", "s0_sel", 8'h00);
    expect_sig("reset", "s1_sel", 8'h00);
    drain();
    S0_dout = 8'h5C;
    S1_dout = 8'h3A;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    expect_sig("park", "m0_grant", 8'h01);
    drain();

    // M1 write to the timer window
    M1_req = 1'b1; M1_address = 8'h25; M1_wr = 1'b1; M1_dout = 8'hA5;
    #1;
    expect_sig("m1_latency", "m1_grant", 8'h00);
    expect_sig("m1_latency", "s_wr", 8'h00);
    expect_sig("m1_latency", "s1_sel", 8'h00);
    drain();
    step();
    expect_sig("m1_write", "m1_grant", 8'h01);
    expect_sig("m1_write", "m0_grant", 8'h00);
    expect_sig("m1_write", "s1_sel", 8'h01);
    expect_sig("m1_write", "s0_sel", 8'h00);
    expect_sig("m1_write", "s_din", 8'hA5);
    expect_sig("m1_write", "s_wr", 8'h01);
    expect_sig("m1_write", "s_address", 8'h25);
    expect_sig("m1_write", "m_din", 8'h3A);
    drain();
    M1_wr = 1'b0;
    #1;
    expect_sig("m1_read", "s_wr", 8'h00);
    drain();
    M1_req = 1'b0; M1_wr = 1'b1;
    #1;
    expect_sig("m1_drop", "m1_grant", 8'h01);
    expect_sig("m1_drop", "s1_sel", 8'h00);
    expect_sig("m1_drop", "m_din", 8'h00);
    expect_sig("m1_drop", "s_wr", 8'h00);
    drain();
    step();
    expect_sig("m1_release", "m0_grant", 8'h01);
    drain();
    M1_wr = 1'b0;

    // M0 owns the bus while M1 waits
    M0_req = 1'b1; M0_address = 8'h03; M1_req = 1'b1;
    #1;
    expect_sig("m0_read", "m_din", 8'h5C);
    expect_sig("m0_read", "s0_sel", 8'h01);
    expect_sig("m0_read", "s_address", 8'h03);
    drain();
    for (int k = 0; k < 3; k++) begin
      step();
      expect_sig("m0_hold", "m0_grant", 8'h01);
      expect_sig("m0_hold", "m1_grant", 8'h00);
      expect_sig("m0_hold", "m_din", 8'h5C);
      drain();
    end
    M0_req = 1'b0;
    #1;
    expect_sig("m0_drop", "m0_grant", 8'h01);
    expect_sig("m0_drop", "m_din", 8'h00);
    expect_sig("m0_drop", "s_address", 8'h03);
    drain();
    step();
    expect_sig("m1_takeover", "m1_grant", 8'h01);
    expect_sig("m1_takeover", "s_address", 8'h25);
    drain();

    // Window boundaries for M0
    M1_req = 1'b0;
    step();
    expect_sig("back_m0", "m0_grant", 8'h01);
    drain();
    M0_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      M0_address = addr_tab[i];
      #1;
      expect_sig("window", "s0_sel", {7'd0, s0_tab[i]});
      expect_sig("window", "s1_sel", {7'd0, s1_tab[i]});
      expect_sig("window", "m_din", din_tab[i]);
      drain();
    end
    M0_wr = 1'b1; M0_dout = 8'hC3;
    #1;
    expect_sig("m0_write", "s_wr", 8'h01);
    expect_sig("m0_write", "s_din", 8'hC3);
    drain();
    M0_req = 1'b0;
    #1;
    expect_sig("m0_wr_noreq", "s_wr", 8'h00);
    drain();
    M0_wr = 1'b0;

    // M1 holds its request for 20 cycles while M0 keeps requesting
    M1_req = 1'b1;
    step();
    expect_sig("hold_start", "m1_grant", 8'h01);
    drain();
    M0_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      logic exp_m1;
      logic exp_to;
      exp_m1 = TIMEOUT_MODE ? (k < 16) : 1'b1;
      exp_to = TIMEOUT_MODE ? (k == 16) : 1'b0;
      step();
      expect_sig("hold", "m1_grant", {7'd0, exp_m1});
      expect_sig("hold", "m0_grant", {7'd0, !exp_m1});
      expect_sig("hold", "bus_timeout", {7'd0, exp_to});
      drain();
    end

    // Asynchronous reset while M1 is granted
    M0_req = 1'b0; M0_address = 8'h12;
    step();
    expect_sig("pre_reset", "m1_grant", 8'h01);
    drain();
    #2;
    reset_n = 1'b0;
    #1;
    expect_sig("async_reset", "m0_grant", 8'h01);
    expect_sig("async_reset", "m1_grant", 8'h00);
    expect_sig("async_reset", "bus_timeout", 8'h00);
    expect_sig("async_reset", "s_address", 8'h12);
    expect_sig("async_reset", "s0_sel", 8'h00);
    drain();
    step();
    expect_sig("in_reset", "m0_grant", 8'h01);
    expect_sig("in_reset", "bus_timeout", 8'h00);
    drain();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    expect_sig("post_reset", "m1_grant", 8'h01);
    expect_sig("post_reset", "bus_timeout", 8'h00);
    drain();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
